// File: rtl/arf_stream_ctrl.sv
// arf_stream_ctrl: stream front end for the arf datapath.
// Eight samples are collected into the tap registers. The block then waits
// LAT cycles for the datapath to settle, and captures the two results both as
// the output pair and as the feedback state for the next frame.
module arf_stream_ctrl #(
    parameter int WIDTH = 16,
    parameter int LAT   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WIDTH-1:0]     s_data,
    input  logic                 fb_clr,
    output logic [8*WIDTH-1:0]   arf_taps,
    output logic [WIDTH-1:0]     arf_fb0,
    output logic [WIDTH-1:0]     arf_fb1,
    input  logic [WIDTH-1:0]     arf_y0,
    input  logic [WIDTH-1:0]     arf_y1,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [WIDTH-1:0]     m_y0,
    output logic [WIDTH-1:0]     m_y1
);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        EVAL = 2'd1,
        OUT  = 2'd2
    } state_t;

    // The settle counter starts at LAT-1, so EVAL lasts exactly LAT cycles.
    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       idx;
    logic [3:0]       cnt;
    logic [WIDTH-1:0] tap_q [8];
    logic             transfer;
    logic             last_sample;
    logic             eval_done;

    // Handshake qualifiers that the FSM and the datapath registers share.
    always_comb begin
        transfer    = s_valid && s_ready;
        last_sample = transfer && (idx == 3'd7);
        eval_done   = (state == EVAL) && (cnt == 4'd0);
    end

    // State register. Reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and handshake outputs. Both handshakes are held low while rst is high.
    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        m_valid   = 1'b0;
        case (state)
            LOAD: begin
                s_ready = !rst;
                if (last_sample) begin
                    state_nxt = EVAL;
                end
            end
            EVAL: begin
                if (cnt == 4'd0) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                m_valid = !rst;
                if (m_ready) begin
                    state_nxt = LOAD;
                end
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

    // The tap index advances on every accepted sample and wraps after tap 8.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= 3'd0;
        end else if (transfer) begin
            idx <= idx + 3'd1;
        end
    end

    // The settle counter is loaded when the frame completes and counts down through EVAL.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 4'd0;
        end else if (last_sample) begin
            cnt <= CNT_INIT;
        end else if ((state == EVAL) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Only the indexed tap is written. The other taps hold, so all taps stay frozen outside LOAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) begin
                tap_q[k] <= '0;
            end
        end else if (transfer) begin
            tap_q[idx] <= s_data;
        end
    end

    // Pack the tap registers onto the datapath bus, with tap 1 in the low slice.
    always_comb begin
        arf_taps = '0;
        for (int k = 0; k < 8; k++) begin
            arf_taps[k*WIDTH +: WIDTH] = tap_q[k];
        end
    end

    // Feedback state. The EVAL capture always wins, and fb_clr only acts while loading.
    always_ff @(posedge clk) begin
        if (rst) begin
            arf_fb0 <= '0;
            arf_fb1 <= '0;
        end else if (eval_done) begin
            arf_fb0 <= arf_y0;
            arf_fb1 <= arf_y1;
        end else if ((state == LOAD) && fb_clr) begin
            arf_fb0 <= '0;
            arf_fb1 <= '0;
        end
    end

    // Result pair. It changes only at the end-of-EVAL capture, so it stays stable through OUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_y0 <= '0;
            m_y1 <= '0;
        end else if (eval_done) begin
            m_y0 <= arf_y0;
            m_y1 <= arf_y1;
        end
    end

endmodule

// File: tb/tb_arf_stream_ctrl.sv
// tb_arf_stream_ctrl: directed frames plus randomized traffic for arf_stream_ctrl.
// The bench checks the DUT against a frame-level reference model.
module tb_arf_stream_ctrl;

   localparam int WIDTH = 16;
   localparam int LAT   = 2;
   localparam int CW    = 8 * WIDTH;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic                 rst;
   logic                 sValid;
   logic                 sReady;
   logic [WIDTH-1:0]     sData;
   logic                 fbClr;
   logic [CW-1:0]        arfTaps;
   logic [WIDTH-1:0]     arfFb0;
   logic [WIDTH-1:0]     arfFb1;
   logic [WIDTH-1:0]     arfY0;
   logic [WIDTH-1:0]     arfY1;
   logic                 mValid;
   logic                 mReady;
   logic [WIDTH-1:0]     mY0;
   logic [WIDTH-1:0]     mY1;

   // Shared controls for the LAT=1 and LAT=15 latency builds
   logic                 altValid;
   logic                 altReady;
   logic                 altClr;
   logic                 a1SReady, a1MValid, a15SReady, a15MValid;
   logic [CW-1:0]        a1Taps, a15Taps;
   logic [WIDTH-1:0]     a1Fb0, a1Fb1, a1Y0, a1Y1, a1MY0, a1MY1;
   logic [WIDTH-1:0]     a15Fb0, a15Fb1, a15Y0, a15Y1, a15MY0, a15MY1;

   int compareCount  = 0;
   int mismatchCount = 0;

   // Reference model: the taps written so far, the number of samples taken,
   // the cycles elapsed since the 8th sample, and the captured values.
   logic [WIDTH-1:0] mTap [8];
   int               nTaken;
   int               waitCyc;
   logic [WIDTH-1:0] mY0Exp, mY1Exp, mFb0Exp, mFb1Exp;

   // Datapath stub: y0 is the wrapped sum of the eight taps, and y1 is tap 1 XOR fb0.
   function automatic logic [WIDTH-1:0] sumTaps(input logic [CW-1:0] t);
      logic [WIDTH-1:0] s;
      s = '0;
      for (int k = 0; k < 8; k++) s = s + t[k*WIDTH +: WIDTH];
      return s;
   endfunction

   assign arfY0 = sumTaps(arfTaps);
   assign arfY1 = arfTaps[WIDTH-1:0] ^ arfFb0;
   assign a1Y0  = sumTaps(a1Taps);
   assign a1Y1  = a1Taps[WIDTH-1:0] ^ a1Fb0;
   assign a15Y0 = sumTaps(a15Taps);
   assign a15Y1 = a15Taps[WIDTH-1:0] ^ a15Fb0;

   arf_stream_ctrl #(.WIDTH(WIDTH), .LAT(LAT)) dut (
      .clk(clock), .rst(rst), .s_valid(sValid), .s_ready(sReady), .s_data(sData),
      .fb_clr(fbClr), .arf_taps(arfTaps), .arf_fb0(arfFb0), .arf_fb1(arfFb1),
      .arf_y0(arfY0), .arf_y1(arfY1), .m_valid(mValid), .m_ready(mReady),
      .m_y0(mY0), .m_y1(mY1)
   );

   arf_stream_ctrl #(.WIDTH(WIDTH), .LAT(1)) dutLat1 (
      .clk(clock), .rst(rst), .s_valid(altValid), .s_ready(a1SReady), .s_data(sData),
      .fb_clr(altClr), .arf_taps(a1Taps), .arf_fb0(a1Fb0), .arf_fb1(a1Fb1),
      .arf_y0(a1Y0), .arf_y1(a1Y1), .m_valid(a1MValid), .m_ready(altReady),
      .m_y0(a1MY0), .m_y1(a1MY1)
   );

   arf_stream_ctrl #(.WIDTH(WIDTH), .LAT(15)) dutLat15 (
      .clk(clock), .rst(rst), .s_valid(altValid), .s_ready(a15SReady), .s_data(sData),
      .fb_clr(altClr), .arf_taps(a15Taps), .arf_fb0(a15Fb0), .arf_fb1(a15Fb1),
      .arf_y0(a15Y0), .arf_y1(a15Y1), .m_valid(a15MValid), .m_ready(altReady),
      .m_y0(a15MY0), .m_y1(a15MY1)
   );

   // The single comparison point, which counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
      compareCount++;
      if (got !== exp) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [CW-1:0] packModelTaps();
      logic [CW-1:0] v;
      for (int k = 0; k < 8; k++) v[k*WIDTH +: WIDTH] = mTap[k];
      return v;
   endfunction

   // Advance the reference model by one clock edge, using the inputs held this cycle
   task automatic modelEdge();
      logic [WIDTH-1:0] y0, y1;
      if (rst) begin
         nTaken = 0; waitCyc = 0;
         for (int k = 0; k < 8; k++) mTap[k] = '0;
         mY0Exp = '0; mY1Exp = '0; mFb0Exp = '0; mFb1Exp = '0;
      end else if (nTaken < 8) begin
         if (fbClr) begin
            mFb0Exp = '0; mFb1Exp = '0;
         end
         if (sValid) begin
            mTap[nTaken] = sData;
            nTaken++;
            waitCyc = 0;
         end
      end else if (waitCyc < LAT) begin
         waitCyc++;
         if (waitCyc == LAT) begin
            y0 = '0;
            for (int k = 0; k < 8; k++) y0 = y0 + mTap[k];
            y1 = mTap[0] ^ mFb0Exp;
            mY0Exp = y0; mY1Exp = y1; mFb0Exp = y0; mFb1Exp = y1;
         end
      end else if (mReady) begin
         nTaken = 0;
      end
   endtask

   // Drive one cycle of inputs from a falling edge, compare all outputs with the
   // model, then step the model on the rising edge and return at the next falling edge
   task automatic applyStimulus(input logic r, input logic sv, input logic [WIDTH-1:0] sd,
                                input logic clr, input logic mr);
      rst = r; sValid = sv; sData = sd; fbClr = clr; mReady = mr;
      #1;
      checkOutput("s_ready", CW'(sReady), CW'(!r && nTaken < 8));
      checkOutput("m_valid", CW'(mValid), CW'(!r && nTaken == 8 && waitCyc >= LAT));
      checkOutput("m_y0", CW'(mY0), CW'(mY0Exp));
      checkOutput("m_y1", CW'(mY1), CW'(mY1Exp));
      checkOutput("arf_fb0", CW'(arfFb0), CW'(mFb0Exp));
      checkOutput("arf_fb1", CW'(arfFb1), CW'(mFb1Exp));
      checkOutput("arf_taps", arfTaps, packModelTaps());
      @(posedge clock);
      modelEdge();
      @(negedge clock);
   endtask

   // Send eight back-to-back samples base, base+1, ..., base+7
   task automatic sendFrame(input logic [WIDTH-1:0] base);
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, base + WIDTH'(i), 1'b0, 1'b0);
   endtask

   // Idle with m_ready low until the result is valid, within a fixed cycle budget
   task automatic waitValid(input string tag);
      int n;
      n = 0;
      while (!mValid && n < 30) begin
         applyStimulus(1'b0, 1'b0, WIDTH'($urandom), 1'b0, 1'b0);
         n++;
      end
      if (!mValid) checkOutput(tag, CW'(0), CW'(1));
   endtask

   // Main sequence: the directed scenarios first, then randomized traffic
   initial begin
      logic [CW-1:0] expTaps;
      int first1, first15;
      rst = 1'b1; sValid = 1'b0; sData = '0; fbClr = 1'b0; mReady = 1'b0;
      altValid = 1'b0; altReady = 1'b1; altClr = 1'b0;
      @(negedge clock);
      @(posedge clock);
      modelEdge();
      @(negedge clock);
      applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
      rst = 1'b0;
      #1;
      checkOutput("rst_release_s_ready", CW'(sReady), CW'(1));

      // Latency of the LAT=1 and LAT=15 builds. The main DUT idles in LOAD meanwhile.
      for (int i = 0; i < 8; i++) begin
         altValid = 1'b1; sData = WIDTH'(i + 1);
         @(posedge clock);
         @(negedge clock);
      end
      altValid = 1'b0;
      first1 = -1; first15 = -1;
      for (int k = 0; k < 40; k++) begin
         if (a1MValid && first1 < 0) first1 = k;
         if (a15MValid && first15 < 0) first15 = k;
         @(posedge clock);
         @(negedge clock);
      end
      checkOutput("lat1_cycles", CW'(first1), CW'(1));
      checkOutput("lat15_cycles", CW'(first15), CW'(15));
      checkOutput("lat1_y0", CW'(a1MY0), CW'(36));
      checkOutput("lat15_y0", CW'(a15MY0), CW'(36));

      // Frame of samples 1..8 sent back to back
      sendFrame(WIDTH'(1));
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) expTaps[k*WIDTH +: WIDTH] = WIDTH'(k + 1);
      checkOutput("f1_m_valid", CW'(mValid), CW'(1));
      checkOutput("f1_m_y0", CW'(mY0), CW'(36));
      checkOutput("f1_m_y1", CW'(mY1), CW'(1));
      checkOutput("f1_fb0", CW'(arfFb0), CW'(36));
      checkOutput("f1_fb1", CW'(arfFb1), CW'(1));
      checkOutput("f1_taps", arfTaps, expTaps);
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);

      // A fb_clr pulse in LOAD clears the feedback
      applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
      checkOutput("clr_fb0", CW'(arfFb0), CW'(0));
      checkOutput("clr_fb1", CW'(arfFb1), CW'(0));

      // Frame with s_valid toggling, then OUT held for 5 cycles
      for (int i = 0; i < 16; i++)
         applyStimulus(1'b0, 1'((i % 2) == 0), WIDTH'(100 + i), 1'b0, 1'b0);
      waitValid("f2_timeout");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'(i % 2), WIDTH'($urandom), 1'b0, 1'b0);
         checkOutput("f2_hold_m_valid", CW'(mValid), CW'(1));
         checkOutput("f2_hold_s_ready", CW'(sReady), CW'(0));
         checkOutput("f2_hold_m_y0", CW'(mY0), CW'(856));
      end
      applyStimulus(1'b0, 1'b1, WIDTH'(16'hBEEF), 1'b0, 1'b1);
      checkOutput("f2_release_s_ready", CW'(sReady), CW'(1));

      // fb_clr during EVAL is ignored, and the capture lands in the feedback
      sendFrame(WIDTH'(1));
      applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
      checkOutput("evalclr_fb0", CW'(arfFb0), CW'(36));
      checkOutput("evalclr_m_y0", CW'(mY0), CW'(36));
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);

      // Reset after 5 samples, then a fresh frame of 11..18
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, WIDTH'(50 + i), 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, WIDTH'(77), 1'b0, 1'b0);
      checkOutput("midload_rst_taps", arfTaps, CW'(0));
      sendFrame(WIDTH'(11));
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
      checkOutput("fresh_tap1", CW'(arfTaps[WIDTH-1:0]), CW'(11));
      checkOutput("fresh_m_y0", CW'(mY0), CW'(116));
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);

      // Reset while in OUT clears the result and the feedback
      sendFrame(WIDTH'(21));
      waitValid("f5_timeout");
      applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
      checkOutput("outrst_m_valid", CW'(mValid), CW'(0));
      checkOutput("outrst_m_y0", CW'(mY0), CW'(0));
      checkOutput("outrst_m_y1", CW'(mY1), CW'(0));
      checkOutput("outrst_fb0", CW'(arfFb0), CW'(0));
      checkOutput("outrst_fb1", CW'(arfFb1), CW'(0));
      rst = 1'b0;
      #1;
      checkOutput("outrst_s_ready", CW'(sReady), CW'(1));

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(1'($urandom_range(63) == 0), 1'($urandom_range(1)), WIDTH'($urandom),
                       1'($urandom_range(7) == 0), 1'($urandom_range(4) < 2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
